// File: rtl/aoi_arc_mon_pkg.sv
// ============================================================================
//  Module      : aoi_arc_mon_pkg
//  Description : Shared helpers for the AOI sensitised-arc activity monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aoi_arc_mon_pkg;

    localparam int c_max_w = 64;

    typedef logic [c_max_w-1:0] vec_t;

    function automatic int n_arc(input int groups, input int inputs);
        return groups * inputs + 1;
    endfunction

    // Inverted OR of per-group ANDs; bit g*inputs+i is input i of group g.
    function automatic logic aoi_eval(input int groups, input int inputs, input vec_t vec);
        logic any_grp;
        logic grp;
        any_grp = 1'b0;
        for (int g = 0; g < groups; g++) begin
            grp = 1'b1;
            for (int i = 0; i < inputs; i++) begin
                grp = grp & vec[g*inputs+i];
            end
            any_grp = any_grp | grp;
        end
        return ~any_grp;
    endfunction

    function automatic vec_t sat_inc(input vec_t value, input int unsigned width);
        vec_t max_val;
        max_val = (width >= c_max_w) ? '1 : ((vec_t'(1) << width) - vec_t'(1));
        return (value >= max_val) ? max_val : value + vec_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aoi_arc_sat_counter.sv
// ============================================================================
//  Module      : aoi_arc_sat_counter
//  Description : Saturating activity counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_arc_sat_counter
    import aoi_arc_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= CNT_W'(sat_inc(vec_t'(r_q), CNT_W));
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/aoi_arc_activity_monitor.sv
// ============================================================================
//  Module      : aoi_arc_activity_monitor
//  Description : Registered AOI gate with per-input sensitised-arc counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_arc_activity_monitor
    import aoi_arc_mon_pkg::*;
#(
    parameter int GROUPS = 3,
    parameter int INPUTS = 2,
    parameter int CNT_W  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      en,
    input  logic [GROUPS*INPUTS-1:0]                  in,
    output logic                                      zn,
    input  logic                                      clr,
    input  logic                                      rd_req,
    input  logic [$clog2(n_arc(GROUPS, INPUTS))-1:0]  arc_sel,
    output logic                                      rd_ack,
    output logic [CNT_W-1:0]                          rd_data
);

    localparam int c_n_in  = GROUPS * INPUTS;
    localparam int c_n_arc = n_arc(GROUPS, INPUTS);

    logic                r_zn;
    logic [c_n_in-1:0]   r_prev;
    logic                r_pv;
    logic                r_rd_ack;
    logic [CNT_W-1:0]    r_rd_data;

    logic                w_f;
    logic [c_n_in-1:0]   w_d;
    logic                w_evt;
    logic                w_single;
    logic                w_multi;
    logic [c_n_arc-1:0]  w_inc;
    logic [CNT_W-1:0]    w_cnt [c_n_arc];
    logic [CNT_W-1:0]    w_rd_mux;

    assign w_f   = aoi_eval(GROUPS, INPUTS, vec_t'(in));
    assign w_d   = in ^ r_prev;
    assign w_evt = en & r_pv & (w_f != r_zn);

    // A nonzero vector with its lowest set bit cleared is zero iff exactly one bit changed.
    assign w_single = (w_d != '0) && ((w_d & (w_d - c_n_in'(1))) == '0);
    assign w_multi  = (w_d != '0) && !w_single;

    always_comb begin
        w_inc = '0;
        for (int j = 0; j < c_n_in; j++) begin
            w_inc[j] = w_evt & w_single & w_d[j];
        end
        w_inc[c_n_in] = w_evt & w_multi;
    end

    generate
        for (genvar j = 0; j < c_n_arc; j++) begin : g_arc
            aoi_arc_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (clr),
                .inc (w_inc[j]),
                .q   (w_cnt[j])
            );
        end
    endgenerate

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int j = 0; j < c_n_arc; j++) begin
            if (int'(arc_sel) == j) begin
                w_rd_mux = w_cnt[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zn      <= 1'b1;
            r_prev    <= '0;
            r_pv      <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (en) begin
                r_zn   <= w_f;
                r_prev <= in;
                r_pv   <= 1'b1;
            end
            r_rd_ack <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign zn      = r_zn;
    assign rd_ack  = r_rd_ack;
    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_aoi_arc_activity_monitor.sv
// ============================================================================
//  Module      : tb_aoi_arc_activity_monitor
//  Description : Scoreboard bench for 16-bit and 4-bit counter instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aoi_arc_activity_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        rd_req = 1'b0;
    logic [5:0]  in_v = '0;
    logic [2:0]  arc_sel = '0;

    logic        zn16, ack16, zn4, ack4;
    logic [15:0] data16;
    logic [3:0]  data4;

    int          total = 0;
    int          bad = 0;
    logic [31:0] q16[$];
    logic [31:0] q4[$];

    always #5 clk = ~clk;

    aoi_arc_activity_monitor #(.GROUPS(3), .INPUTS(2), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .in(in_v), .zn(zn16), .clr(clr),
        .rd_req(rd_req), .arc_sel(arc_sel), .rd_ack(ack16), .rd_data(data16)
    );

    aoi_arc_activity_monitor #(.GROUPS(3), .INPUTS(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .in(in_v), .zn(zn4), .clr(clr),
        .rd_req(rd_req), .arc_sel(arc_sel), .rd_ack(ack4), .rd_data(data4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [5:0] v);
        en   = 1'b1;
        in_v = v;
        tick();
        en   = 1'b0;
    endtask

    task automatic read(input logic [2:0] sel, input logic [31:0] e16, input logic [31:0] e4);
        rd_req  = 1'b1;
        arc_sel = sel;
        q16.push_back(e16);
        q4.push_back(e4);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic chk_zn(input string name, input logic exp);
        chk({name, "/zn16"}, {31'd0, zn16}, {31'd0, exp});
        chk({name, "/zn4"}, {31'd0, zn4}, {31'd0, exp});
    endtask

    task automatic chk_noack(input string name);
        chk({name, "/ack16"}, {31'd0, ack16}, 32'd0);
        chk({name, "/ack4"}, {31'd0, ack4}, 32'd0);
    endtask

    // Read-data monitor: every ack consumes one expectation.
    always @(negedge clk) begin
        if (ack16 === 1'b1) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL rd16_unexpected_ack: got ack expected none at %0t", $time);
            end else begin
                chk("rd16", {16'd0, data16}, q16.pop_front());
            end
        end
        if (ack4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL rd4_unexpected_ack: got ack expected none at %0t", $time);
            end else begin
                chk("rd4", {28'd0, data4}, q4.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk_zn("reset", 1'b1);
        chk_noack("reset");
        rst = 1'b0;
        for (int s = 0; s < 7; s++) read(3'(s), 0, 0);

        // Only the A1 change flips ZN, so only arc0 counts.
        samp(6'b000000);
        chk_zn("pv0", 1'b1);
        samp(6'b000010);
        chk_zn("a2_only", 1'b1);
        samp(6'b000011);
        chk_zn("a1_sens", 1'b0);
        read(0, 1, 1);
        read(1, 0, 0);

        samp(6'b001111);
        for (int k = 0; k < 5; k++) begin
            samp((k % 2 == 0) ? 6'b001110 : 6'b001111);
            chk_zn("a1_blocked", 1'b0);
        end
        read(0, 1, 1);
        read(6, 0, 0);

        samp(6'b000000);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        samp(6'b000011);
        chk_zn("multi", 1'b0);
        read(6, 1, 1);
        read(0, 0, 0);
        read(1, 0, 0);

        samp(6'b000000);
        samp(6'b100000);
        for (int k = 0; k < 20; k++) begin
            samp((k % 2 == 0) ? 6'b110000 : 6'b100000);
        end
        chk_zn("c1_end", 1'b1);
        read(4, 20, 15);
        read(6, 2, 2);

        clr = 1'b1;
        samp(6'b110000);
        clr = 1'b0;
        chk_zn("clr_evt", 1'b0);
        read(4, 0, 0);
        samp(6'b100000);
        read(4, 1, 1);

        rd_req  = 1'b1;
        arc_sel = 3'd4;
        clr     = 1'b1;
        q16.push_back(1);
        q4.push_back(1);
        tick();
        rd_req = 1'b0;
        clr    = 1'b0;
        read(4, 0, 0);
        read(7, 0, 0);
        read(6, 0, 0);

        read(7, 0, 0);
        rst = 1'b1;
        tick();
        chk_noack("rst_after_req");
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        chk_noack("rst_with_req");
        rst = 1'b0;
        chk_zn("post_rst", 1'b1);
        samp(6'b110000);
        chk_zn("post_rst_samp", 1'b0);
        read(6, 0, 0);
        read(4, 0, 0);
        samp(6'b100000);
        read(4, 1, 1);

        for (int w = 0; w < 10 && (q16.size() != 0 || q4.size() != 0); w++) tick();
        chk("pending16", q16.size(), 0);
        chk("pending4", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
